sctr_lsu: RTL and testbench
===========================

SCTR_LSU -- requirements
Module: sctr_lsu

Interface
REQ-001 Parameters SHALL be (name, default, meaning): AW, 32, address width; DW, 32, data width (32 or 64 only); TO_W, 8, timeout counter width; TO_EN, 1, timeout enable.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock, rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- req_valid, in, 1, memory access request.
- req_we, in, 1, 1=store, 0=load.
- req_addr, in, AW, byte address.
- req_wdata, in, DW, lane-aligned store data.
- req_wmask, in, DW/8, store byte enables.
- req_size, in, 2, 0=byte, 1=half, 2=word, 3=dword.
- req_signed, in, 1, sign-extend load.
- kill_i, in, 1, trap/halt abort.
- done_o, out, 1, access complete; writeback allowed.
- hold_o, out, 1, pipeline stall.
- rdata_o, out, DW, formatted load data.
- misalign_o, out, 1, misaligned pulse.
- err_o, out, 1, bus error pulse.
- timeout_o, out, 1, timeout pulse.
- err_addr_o, out, AW, address of the last faulting access.
- icb_cmd_valid, out, 1; icb_cmd_ready, in, 1; icb_cmd_addr, out, AW; icb_cmd_read, out, 1; icb_cmd_wdata, out, DW; icb_cmd_wmask, out, DW/8.
- icb_rsp_valid, in, 1; icb_rsp_ready, out, 1; icb_rsp_err, in, 1; icb_rsp_rdata, in, DW.

Function
REQ-003 FSM states SHALL be IDLE, CMD, RSP.
REQ-004 In IDLE, an aligned request with kill_i=0 SHALL drive icb_cmd_valid=1 combinationally from req_* inputs and SHALL capture addr/we/wdata/wmask/size/signed into registers on the same edge.
REQ-005 Misalignment SHALL be defined as half with addr[0]=1, word with addr[1:0]!=0, dword with addr[2:0]!=0, or size=3 with DW=32. A misaligned request SHALL issue no command, SHALL pulse misalign_o for one cycle, SHALL latch err_addr_o, and SHALL leave the FSM in IDLE.
REQ-006 icb_cmd_addr SHALL be the request address with its low log2(DW/8) bits forced to 0. icb_cmd_read SHALL equal ~we. icb_rsp_ready SHALL be constant 1.
REQ-007 Transitions from IDLE SHALL be as follows:
- cmd accepted, store: done_o=1 in the same cycle; remain IDLE (posted write).
- cmd accepted, load: go to RSP.
- cmd not accepted: go to CMD.
REQ-008 In CMD, icb_cmd_valid SHALL stay 1 with all cmd fields driven from the captured registers until icb_cmd_ready; kill_i SHALL NOT withdraw the command.
REQ-009 In CMD, acceptance of a store SHALL return the FSM to IDLE with done_o=1, and acceptance of a load SHALL move it to RSP.
REQ-010 In RSP, icb_rsp_valid SHALL return the FSM to IDLE in that cycle, with done_o=1 unless the transaction is killed; minimum load latency SHALL be one cycle after cmd acceptance.
REQ-011 Load formatting SHALL shift icb_rsp_rdata right by 8*addr offset, then zero- or sign-extend (per req_signed) from bit 7/15/31 to DW. Formatted data SHALL be valid on rdata_o only while done_o=1 and SHALL be 0 otherwise.
REQ-012 kill_i asserted in CMD or RSP SHALL set a killed flag. The transaction SHALL still complete on the bus, with done_o, err_o and timeout_o suppressed at completion, and the flag SHALL be cleared on the return to IDLE. kill_i in IDLE SHALL suppress the command.
REQ-013 icb_rsp_err=1 with icb_rsp_valid SHALL pulse err_o, latch err_addr_o, and still assert done_o (non-killed).
REQ-014 With TO_EN=1, a counter SHALL clear on leaving IDLE and increment every cycle in CMD/RSP. On reaching all-ones it SHALL pulse timeout_o, latch err_addr_o, assert done_o and return to IDLE. A response arriving later while in IDLE SHALL be discarded silently.
REQ-015 hold_o SHALL equal (req_valid & ~done_o & ~misalign_o) | (state!=IDLE).
REQ-016 A response arriving in the same cycle the counter reaches all-ones SHALL win, with no timeout_o.

Reset
REQ-017 rst_n=0 SHALL asynchronously force IDLE and clear the counter and killed flag. It SHALL drive done_o, hold_o, misalign_o, err_o, timeout_o and icb_cmd_valid to 0, err_addr_o and rdata_o to 0, and icb_rsp_ready to 1.
REQ-018 Reset mid-transaction SHALL abandon it with no done_o after release.

Verification
REQ-019 Load byte signed, DW=32, addr=0x1003, ready=1, rsp rdata=0x80FF_FFFF one cycle later -> icb_cmd_addr=0x1000, done_o=1 that cycle, rdata_o=0xFFFF_FF80.
REQ-020 Store with ready low for 3 cycles -> icb_cmd_valid held 4 cycles with stable fields; done_o=1 only on the ready cycle; hold_o=1 before.
REQ-021 Load half at addr=0x2001 -> no icb_cmd_valid, misalign_o=1 one cycle, err_addr_o=0x2001.
REQ-022 TO_W=4, load accepted, no response -> timeout_o and done_o in the 15th RSP cycle; a later rsp_valid is ignored.
REQ-023 kill_i pulse during RSP -> response consumed, done_o stays 0, FSM back in IDLE.
REQ-024 rsp_err=1 on a load -> err_o=1 and done_o=1 in the same cycle, err_addr_o=request address.

Source files
------------

// File: rtl/sctr_lsu.sv
// sctr_lsu: load/store unit bridging a single-issue pipeline to an ICB bus.
// Posted stores, blocking loads with lane extraction, killable in flight, with a bus timeout.
module sctr_lsu #(
   parameter int AW    = 32,
   parameter int DW    = 32,
   parameter int TO_W  = 8,
   parameter bit TO_EN = 1
)(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   input  logic            req_we,
   input  logic [AW-1:0]   req_addr,
   input  logic [DW-1:0]   req_wdata,
   input  logic [DW/8-1:0] req_wmask,
   input  logic [1:0]      req_size,
   input  logic            req_signed,
   input  logic            kill_i,
   output logic            done_o,
   output logic            hold_o,
   output logic [DW-1:0]   rdata_o,
   output logic            misalign_o,
   output logic            err_o,
   output logic            timeout_o,
   output logic [AW-1:0]   err_addr_o,
   output logic            icb_cmd_valid,
   input  logic            icb_cmd_ready,
   output logic [AW-1:0]   icb_cmd_addr,
   output logic            icb_cmd_read,
   output logic [DW-1:0]   icb_cmd_wdata,
   output logic [DW/8-1:0] icb_cmd_wmask,
   input  logic            icb_rsp_valid,
   output logic            icb_rsp_ready,
   input  logic            icb_rsp_err,
   input  logic [DW-1:0]   icb_rsp_rdata
);
   localparam int MW = DW/8;
   localparam int OW = $clog2(MW);
   typedef enum logic [1:0] {IDLE, CMD, RSP} state_t;
   state_t          state, state_n;
   logic [AW-1:0]   addr_q, err_addr_q;
   logic [DW-1:0]   wdata_q;
   logic [MW-1:0]   wmask_q;
   logic [1:0]      size_q;
   logic            we_q, signed_q, killed_q;
   logic [TO_W-1:0] cnt;
   logic            idle, mis, issue, mis_req, killed, to_hit, ld_done;
   logic [DW-1:0]   sh, ext_b, ext_h, ext_w, fmt;
   assign idle    = (state == IDLE);
   assign mis     = (req_size == 2'd1 & req_addr[0]) |
                    (req_size == 2'd2 & |req_addr[1:0]) |
                    (req_size == 2'd3 & ((DW == 32) | |req_addr[2:0]));
   assign issue   = rst_n & idle & req_valid & ~kill_i & ~mis;
   assign mis_req = rst_n & idle & req_valid & ~kill_i & mis;
   assign killed  = killed_q | kill_i;
   // Fires on the cycle whose increment would make the counter all-ones.
   assign to_hit  = TO_EN & ~idle & (cnt == {{(TO_W-1){1'b1}}, 1'b0});
   assign ld_done = (state == RSP) & icb_rsp_valid & ~killed;
   assign icb_cmd_addr  = {(idle ? req_addr[AW-1:OW] : addr_q[AW-1:OW]), {OW{1'b0}}};
   assign icb_cmd_read  = ~(idle ? req_we : we_q);
   assign icb_cmd_wdata = idle ? req_wdata : wdata_q;
   assign icb_cmd_wmask = idle ? req_wmask : wmask_q;
   assign icb_rsp_ready = 1'b1;
   assign misalign_o    = mis_req;
   assign err_addr_o    = err_addr_q;
   assign hold_o        = rst_n & ((req_valid & ~done_o & ~misalign_o) | ~idle);
   assign sh      = icb_rsp_rdata >> {addr_q[OW-1:0], 3'b000};
   assign ext_b   = signed_q ? DW'($signed(sh[7:0]))  : DW'(sh[7:0]);
   assign ext_h   = signed_q ? DW'($signed(sh[15:0])) : DW'(sh[15:0]);
   assign ext_w   = signed_q ? DW'($signed(sh[31:0])) : DW'(sh[31:0]);
   assign fmt     = size_q == 2'd0 ? ext_b : size_q == 2'd1 ? ext_h : size_q == 2'd2 ? ext_w : sh;
   assign rdata_o = ld_done ? fmt : '0;
   always_comb begin
      state_n       = state;
      done_o        = 1'b0;
      err_o         = 1'b0;
      timeout_o     = 1'b0;
      icb_cmd_valid = 1'b0;
      case (state)
         IDLE: begin
            icb_cmd_valid = issue;
            if (issue) begin
               if (!icb_cmd_ready) state_n = CMD;
               else if (req_we) done_o = 1'b1;
               else state_n = RSP;
            end
         end
         CMD: begin
            icb_cmd_valid = 1'b1;
            if (icb_cmd_ready) begin
               state_n = we_q ? IDLE : RSP;
               done_o  = we_q & ~killed;
            end else if (to_hit) begin
               state_n   = IDLE;
               done_o    = ~killed;
               timeout_o = ~killed;
            end
         end
         RSP: begin
            if (icb_rsp_valid) begin
               state_n = IDLE;
               done_o  = ~killed;
               err_o   = ~killed & icb_rsp_err;
            end else if (to_hit) begin
               state_n   = IDLE;
               done_o    = ~killed;
               timeout_o = ~killed;
            end
         end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         killed_q   <= 1'b0;
         cnt        <= '0;
         addr_q     <= '0;
         we_q       <= 1'b0;
         wdata_q    <= '0;
         wmask_q    <= '0;
         size_q     <= 2'd0;
         signed_q   <= 1'b0;
         err_addr_q <= '0;
      end else begin
         state    <= state_n;
         killed_q <= (state_n == IDLE) ? 1'b0 : killed;
         cnt      <= idle ? '0 : cnt + 1'b1;
         if (issue) begin
            addr_q   <= req_addr;
            we_q     <= req_we;
            wdata_q  <= req_wdata;
            wmask_q  <= req_wmask;
            size_q   <= req_size;
            signed_q <= req_signed;
         end
         if (mis_req) err_addr_q <= req_addr;
         else if (err_o | timeout_o) err_addr_q <= addr_q;
      end
   end
endmodule

// File: tb/tb_sctr_lsu.sv
// tb_sctr_lsu: directed scenario bench for sctr_lsu (DW=32, TO_W=4).
module tb_sctr_lsu;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        req_valid, req_we, req_signed, kill_i;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_wmask;
   logic [1:0]  req_size;
   logic        done_o, hold_o, misalign_o, err_o, timeout_o;
   logic [31:0] rdata_o, err_addr_o;
   logic        icb_cmd_valid, icb_cmd_ready, icb_cmd_read, icb_rsp_valid, icb_rsp_ready, icb_rsp_err;
   logic [31:0] icb_cmd_addr, icb_cmd_wdata, icb_rsp_rdata;
   logic [3:0]  icb_cmd_wmask;
   int n_chk = 0, n_fail = 0;
   logic [31:0] la [5] = '{32'h1003, 32'h1002, 32'h1002, 32'h1001, 32'h1004};
   logic [1:0]  ls [5] = '{2'd0, 2'd1, 2'd1, 2'd0, 2'd2};
   logic        lg [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
   logic [31:0] ld [5] = '{32'h80FF_FFFF, 32'h8001_1234, 32'h8001_1234, 32'h1234_F678, 32'hDEAD_BEEF};
   logic [31:0] le [5] = '{32'hFFFF_FF80, 32'h0000_8001, 32'hFFFF_8001, 32'h0000_00F6, 32'hDEAD_BEEF};
   logic [31:0] ma [3] = '{32'h2001, 32'h2006, 32'h2000};
   logic [1:0]  ms [3] = '{2'd1, 2'd2, 2'd3};
   always #5 clk = ~clk;
   sctr_lsu #(.AW(32), .DW(32), .TO_W(4), .TO_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_wmask(req_wmask), .req_size(req_size), .req_signed(req_signed),
      .kill_i(kill_i), .done_o(done_o), .hold_o(hold_o), .rdata_o(rdata_o), .misalign_o(misalign_o),
      .err_o(err_o), .timeout_o(timeout_o), .err_addr_o(err_addr_o),
      .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready), .icb_cmd_addr(icb_cmd_addr),
      .icb_cmd_read(icb_cmd_read), .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
      .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready), .icb_rsp_err(icb_rsp_err),
      .icb_rsp_rdata(icb_rsp_rdata));
   task clr;
      req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_wmask = 0; req_size = 0;
      req_signed = 0; kill_i = 0; icb_cmd_ready = 0; icb_rsp_valid = 0; icb_rsp_err = 0; icb_rsp_rdata = 0;
   endtask
   task load_req(input logic [31:0] a);
      @(negedge clk); clr; req_valid = 1; req_addr = a; req_size = 2'd2; icb_cmd_ready = 1;
   endtask
   task test_reset;
      clr; req_valid = 1; req_size = 2'd2; req_addr = 32'h10; icb_cmd_ready = 1;
      repeat (2) @(negedge clk);
      #1;
      n_chk++; if ({done_o, hold_o, misalign_o, err_o, timeout_o, icb_cmd_valid} !== 6'b0) begin n_fail++; $display("FAIL reset_outs: got %b expected 000000", {done_o, hold_o, misalign_o, err_o, timeout_o, icb_cmd_valid}); end
      n_chk++; if (icb_rsp_ready !== 1'b1) begin n_fail++; $display("FAIL reset_rsp_ready: got %b expected 1", icb_rsp_ready); end
      n_chk++; if ({err_addr_o, rdata_o} !== 64'h0) begin n_fail++; $display("FAIL reset_regs: got %h expected 0", {err_addr_o, rdata_o}); end
      @(negedge clk); clr; rst_n = 1;
   endtask
   task test_load_format;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); clr; req_valid = 1; req_addr = la[i]; req_size = ls[i]; req_signed = lg[i]; icb_cmd_ready = 1;
         #1;
         n_chk++; if ({icb_cmd_valid, icb_cmd_read, icb_cmd_addr} !== {2'b11, la[i] & 32'hFFFF_FFFC}) begin n_fail++; $display("FAIL ld_cmd[%0d]: got %b/%b/%h expected 1/1/%h", i, icb_cmd_valid, icb_cmd_read, icb_cmd_addr, la[i] & 32'hFFFF_FFFC); end
         n_chk++; if ({done_o, hold_o} !== 2'b01) begin n_fail++; $display("FAIL ld_issue[%0d]: got done/hold %b expected 01", i, {done_o, hold_o}); end
         for (int w = 0; w < i % 2; w++) begin
            @(negedge clk); clr;
            #1;
            n_chk++; if ({done_o, hold_o, rdata_o} !== {2'b01, 32'h0}) begin n_fail++; $display("FAIL ld_wait[%0d]: got %b %b %h expected 0 1 0", i, done_o, hold_o, rdata_o); end
         end
         @(negedge clk); clr; icb_rsp_valid = 1; icb_rsp_rdata = ld[i];
         #1;
         n_chk++; if ({done_o, rdata_o} !== {1'b1, le[i]}) begin n_fail++; $display("FAIL ld_data[%0d]: got %b %h expected 1 %h", i, done_o, rdata_o, le[i]); end
         @(negedge clk); clr;
         #1;
         n_chk++; if ({done_o, hold_o, rdata_o} !== 34'h0) begin n_fail++; $display("FAIL ld_after[%0d]: got %b %b %h expected 0 0 0", i, done_o, hold_o, rdata_o); end
      end
   endtask
   task test_store_wait;
      @(negedge clk); clr; req_valid = 1; req_we = 1; req_addr = 32'h3004; req_wdata = 32'hA5A5_5A5A; req_wmask = 4'hF; req_size = 2'd2;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) begin @(negedge clk); req_addr = 32'hFFFF_FFF0; req_wdata = 0; req_wmask = 0; end
         icb_cmd_ready = (k == 3);
         #1;
         n_chk++; if ({icb_cmd_valid, icb_cmd_read, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask} !== {2'b10, 32'h3004, 32'hA5A5_5A5A, 4'hF}) begin n_fail++; $display("FAIL st_fields[%0d]: got %b %b %h %h %h expected 1 0 3004 a5a55a5a f", k, icb_cmd_valid, icb_cmd_read, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask); end
         n_chk++; if ({done_o, hold_o} !== {(k == 3), 1'b1}) begin n_fail++; $display("FAIL st_done_hold[%0d]: got %b%b expected %b1", k, done_o, hold_o, (k == 3)); end
      end
      @(negedge clk); clr;
      #1;
      n_chk++; if ({icb_cmd_valid, hold_o, done_o} !== 3'b0) begin n_fail++; $display("FAIL st_idle: got %b expected 000", {icb_cmd_valid, hold_o, done_o}); end
      @(negedge clk); clr; req_valid = 1; req_we = 1; req_addr = 32'h3008; req_wdata = 32'h1122_3344; req_wmask = 4'h3; req_size = 2'd2; icb_cmd_ready = 1;
      #1;
      n_chk++; if ({icb_cmd_valid, done_o, hold_o, icb_cmd_addr} !== {3'b110, 32'h3008}) begin n_fail++; $display("FAIL st_posted: got %b%b%b %h expected 110 3008", icb_cmd_valid, done_o, hold_o, icb_cmd_addr); end
      @(negedge clk); clr;
      #1;
      n_chk++; if ({icb_cmd_valid, done_o, hold_o} !== 3'b0) begin n_fail++; $display("FAIL st_posted_idle: got %b expected 000", {icb_cmd_valid, done_o, hold_o}); end
   endtask
   task test_misalign;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); clr; req_valid = 1; req_addr = ma[i]; req_size = ms[i]; icb_cmd_ready = 1;
         #1;
         n_chk++; if ({icb_cmd_valid, misalign_o, hold_o, done_o} !== 4'b0100) begin n_fail++; $display("FAIL mis[%0d]: got %b expected 0100", i, {icb_cmd_valid, misalign_o, hold_o, done_o}); end
         @(negedge clk); clr;
         #1;
         n_chk++; if ({misalign_o, err_addr_o} !== {1'b0, ma[i]}) begin n_fail++; $display("FAIL mis_addr[%0d]: got %b %h expected 0 %h", i, misalign_o, err_addr_o, ma[i]); end
      end
   endtask
   task test_timeout;
      load_req(32'h4000);
      #1;
      n_chk++; if (icb_cmd_valid !== 1'b1) begin n_fail++; $display("FAIL to_issue: got %b expected 1", icb_cmd_valid); end
      for (int c = 1; c <= 15; c++) begin
         @(negedge clk); clr;
         #1;
         n_chk++; if ({timeout_o, done_o, hold_o} !== {(c == 15), (c == 15), 1'b1}) begin n_fail++; $display("FAIL to_cycle[%0d]: got %b expected %b%b1", c, {timeout_o, done_o, hold_o}, (c == 15), (c == 15)); end
      end
      @(negedge clk); clr; icb_rsp_valid = 1; icb_rsp_err = 1; icb_rsp_rdata = 32'h1234_5678;
      #1;
      n_chk++; if ({done_o, err_o, timeout_o, hold_o, icb_cmd_valid, rdata_o} !== 37'h0) begin n_fail++; $display("FAIL to_late_rsp: got %b %h expected 00000 0", {done_o, err_o, timeout_o, hold_o, icb_cmd_valid}, rdata_o); end
      n_chk++; if (err_addr_o !== 32'h4000) begin n_fail++; $display("FAIL to_err_addr: got %h expected 4000", err_addr_o); end
      load_req(32'h4010);
      for (int c = 1; c < 15; c++) begin @(negedge clk); clr; end
      @(negedge clk); clr; icb_rsp_valid = 1; icb_rsp_rdata = 32'hCAFE_F00D;
      #1;
      n_chk++; if ({done_o, timeout_o, rdata_o} !== {2'b10, 32'hCAFE_F00D}) begin n_fail++; $display("FAIL to_rsp_wins: got %b%b %h expected 10 cafef00d", done_o, timeout_o, rdata_o); end
      @(negedge clk); clr;
      #1;
      n_chk++; if ({hold_o, err_addr_o} !== {1'b0, 32'h4000}) begin n_fail++; $display("FAIL to_rsp_wins_idle: got %b %h expected 0 4000", hold_o, err_addr_o); end
   endtask
   task test_kill;
      load_req(32'h5000);
      @(negedge clk); clr; kill_i = 1;
      #1;
      n_chk++; if ({done_o, hold_o} !== 2'b01) begin n_fail++; $display("FAIL kill_rsp_pulse: got %b expected 01", {done_o, hold_o}); end
      @(negedge clk); clr; icb_rsp_valid = 1; icb_rsp_rdata = 32'h55;
      #1;
      n_chk++; if ({done_o, hold_o, rdata_o} !== {2'b01, 32'h0}) begin n_fail++; $display("FAIL kill_rsp_done: got %b%b %h expected 01 0", done_o, hold_o, rdata_o); end
      @(negedge clk); clr;
      #1;
      n_chk++; if ({hold_o, icb_cmd_valid, done_o} !== 3'b0) begin n_fail++; $display("FAIL kill_idle: got %b expected 000", {hold_o, icb_cmd_valid, done_o}); end
      @(negedge clk); clr; req_valid = 1; req_we = 1; req_addr = 32'h5004; req_size = 2'd2; icb_cmd_ready = 1;
      #1;
      n_chk++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL kill_cleared: got %b expected 1", done_o); end
      @(negedge clk); clr; req_valid = 1; req_we = 1; req_addr = 32'h5008; req_size = 2'd2;
      @(negedge clk); kill_i = 1;
      #1;
      n_chk++; if ({icb_cmd_valid, done_o} !== 2'b10) begin n_fail++; $display("FAIL kill_cmd_hold: got %b expected 10", {icb_cmd_valid, done_o}); end
      @(negedge clk); kill_i = 0; icb_cmd_ready = 1;
      #1;
      n_chk++; if ({icb_cmd_valid, done_o} !== 2'b10) begin n_fail++; $display("FAIL kill_cmd_accept: got %b expected 10", {icb_cmd_valid, done_o}); end
      @(negedge clk); clr;
      #1;
      n_chk++; if (hold_o !== 1'b0) begin n_fail++; $display("FAIL kill_cmd_idle: got %b expected 0", hold_o); end
      @(negedge clk); clr; req_valid = 1; req_addr = 32'h500C; req_size = 2'd2; icb_cmd_ready = 1; kill_i = 1;
      #1;
      n_chk++; if ({icb_cmd_valid, done_o} !== 2'b00) begin n_fail++; $display("FAIL kill_in_idle: got %b expected 00", {icb_cmd_valid, done_o}); end
      @(negedge clk); clr;
   endtask
   task test_rsp_err;
      load_req(32'h6008);
      @(negedge clk); clr; icb_rsp_valid = 1; icb_rsp_err = 1;
      #1;
      n_chk++; if ({err_o, done_o} !== 2'b11) begin n_fail++; $display("FAIL rsp_err: got %b expected 11", {err_o, done_o}); end
      @(negedge clk); clr;
      #1;
      n_chk++; if ({err_o, err_addr_o} !== {1'b0, 32'h6008}) begin n_fail++; $display("FAIL rsp_err_addr: got %b %h expected 0 6008", err_o, err_addr_o); end
   endtask
   task test_reset_mid;
      load_req(32'h7000);
      @(negedge clk); clr;
      #1;
      n_chk++; if (hold_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 1", hold_o); end
      #1 rst_n = 0;
      #1;
      n_chk++; if ({hold_o, icb_cmd_valid, done_o} !== 3'b0) begin n_fail++; $display("FAIL rstmid_async: got %b expected 000", {hold_o, icb_cmd_valid, done_o}); end
      @(negedge clk); rst_n = 1; icb_rsp_valid = 1; icb_rsp_rdata = 32'hAAAA;
      #1;
      n_chk++; if ({done_o, hold_o, rdata_o} !== 34'h0) begin n_fail++; $display("FAIL rstmid_after: got %b%b %h expected 00 0", done_o, hold_o, rdata_o); end
      @(negedge clk); clr;
   endtask
   initial begin
      test_reset;
      test_load_format;
      test_store_wait;
      test_misalign;
      test_timeout;
      test_kill;
      test_rsp_err;
      test_reset_mid;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
